// File: rtl/condicionador_jogada.sv
// Input conditioning for the sequence game: synchronizes and debounces the raw
// buttons, rejects chords, emits one strobe per accepted press, and runs the move watchdog.
`timescale 1ns/1ps
module condicionador_jogada #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       habilita,
   input  logic       zera_timeout,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       tem_jogada,
   output logic       timeout,
   output logic [2:0] db_estado
);

   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      FILTRANDO   = 3'd1,
      PRESSIONADO = 3'd2,
      SOLTANDO    = 3'd3,
      INVALIDO    = 3'd4
   } estado_t;

   estado_t         estado, estado_n;
   logic [3:0]      b_meta, b_s;
   logic [3:0]      cand_q, cand_n;
   logic [DW-1:0]   cnt_q, cnt_n;
   logic [3:0]      jogada_n;
   logic            feita_n;
   logic            b_um;
   logic [TW-1:0]   wd_q;

   // Two-flop synchronizer for the asynchronous buttons
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         b_meta <= 4'd0;
         b_s    <= 4'd0;
      end else begin
         b_meta <= botoes;
         b_s    <= b_meta;
      end
   end

   assign b_um = (b_s != 4'd0) && ((b_s & (b_s - 4'd1)) == 4'd0);

   // State register and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado       <= OCIOSO;
         cand_q       <= 4'd0;
         cnt_q        <= '0;
         jogada       <= 4'd0;
         jogada_feita <= 1'b0;
         tem_jogada   <= 1'b0;
      end else begin
         estado       <= estado_n;
         cand_q       <= cand_n;
         cnt_q        <= cnt_n;
         jogada       <= jogada_n;
         jogada_feita <= feita_n;
         tem_jogada   <= (estado_n == PRESSIONADO);
      end
   end

   // Next-state and output decode
   always_comb begin
      estado_n = estado;
      cand_n   = cand_q;
      cnt_n    = cnt_q;
      jogada_n = jogada;
      feita_n  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (b_um) begin
               estado_n = FILTRANDO;
               cand_n   = b_s;
               cnt_n    = '0;
            end else if (b_s != 4'd0) begin
               estado_n = INVALIDO;
            end
         end
         FILTRANDO: begin
            if (b_s == cand_q) begin
               if (cnt_q == DB_LAST) begin
                  estado_n = PRESSIONADO;
                  // A press accepted while disabled is consumed, never delivered later
                  if (habilita) begin
                     jogada_n = cand_q;
                     feita_n  = 1'b1;
                  end
               end else begin
                  cnt_n = cnt_q + DW'(1);
               end
            end else if (b_s == 4'd0) begin
               estado_n = OCIOSO;
            end else if (b_um) begin
               cand_n = b_s;
               cnt_n  = '0;
            end else begin
               estado_n = INVALIDO;
            end
         end
         PRESSIONADO: begin
            if (b_s != cand_q) begin
               estado_n = SOLTANDO;
               cnt_n    = '0;
            end
         end
         SOLTANDO: begin
            if (b_s != 4'd0) begin
               cnt_n = '0;
            end else if (cnt_q == DB_LAST) begin
               estado_n = OCIOSO;
            end else begin
               cnt_n = cnt_q + DW'(1);
            end
         end
         INVALIDO: begin
            if (b_s == 4'd0) begin
               estado_n = SOLTANDO;
               cnt_n    = '0;
            end
         end
         default: estado_n = OCIOSO;
      endcase
   end

   // Watchdog: a strobe restarts the count but leaves an already-set flag alone
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_q    <= '0;
         timeout <= 1'b0;
      end else if (!habilita || zera_timeout) begin
         wd_q    <= '0;
         timeout <= 1'b0;
      end else if (feita_n) begin
         wd_q <= '0;
      end else if (!timeout) begin
         if (wd_q == TO_LAST) timeout <= 1'b1;
         else                 wd_q    <= wd_q + TW'(1);
      end
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_jogada.sv
// Vector/scoreboard bench for condicionador_jogada with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=10.
`timescale 1ns/1ps
module tb_condicionador_jogada;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] botoes = 4'd0;
   logic       habilita = 1'b0;
   logic       zera_timeout = 1'b0;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       tem_jogada;
   logic       timeout;
   logic [2:0] db_estado;

   condicionador_jogada #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .botoes       (botoes),
      .habilita     (habilita),
      .zera_timeout (zera_timeout),
      .jogada       (jogada),
      .jogada_feita (jogada_feita),
      .tem_jogada   (tem_jogada),
      .timeout      (timeout),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] b;
      logic       h;
      logic       z;
      int         n;
      logic [3:0] jog;
      logic       f;
      logic       tem;
      logic       to;
      logic [2:0] est;
      int         stb;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] b, input logic h, input logic z, input int n,
                      input logic [3:0] jog, input logic f, input logic tem, input logic to,
                      input logic [2:0] est, input int stb);
      vec_t v;
      v.b = b; v.h = h; v.z = z; v.n = n;
      v.jog = jog; v.f = f; v.tem = tem; v.to = to; v.est = est; v.stb = stb;
      vecs.push_back(v);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".jogada"}, 32'(jogada), 32'd0);
      check({tag, ".feita"}, 32'(jogada_feita), 32'd0);
      check({tag, ".tem"}, 32'(tem_jogada), 32'd0);
      check({tag, ".timeout"}, 32'(timeout), 32'd0);
      check({tag, ".estado"}, 32'(db_estado), 32'd0);
   endtask

   // Drive one vector for n edges, counting strobes, then compare against the queued expectation
   task automatic run_vec(input int i);
      vec_t v;
      vec_t e;
      int   stb;
      v = vecs[i];
      botoes = v.b;
      habilita = v.h;
      zera_timeout = v.z;
      exp_q.push_back(v);
      stb = 0;
      repeat (v.n) begin
         @(posedge clock);
         #1;
         if (jogada_feita === 1'b1) stb++;
      end
      e = exp_q.pop_front();
      check($sformatf("v%0d.jogada", i), 32'(jogada), 32'(e.jog));
      check($sformatf("v%0d.feita", i), 32'(jogada_feita), 32'(e.f));
      check($sformatf("v%0d.tem", i), 32'(tem_jogada), 32'(e.tem));
      check($sformatf("v%0d.timeout", i), 32'(timeout), 32'(e.to));
      check($sformatf("v%0d.estado", i), 32'(db_estado), 32'(e.est));
      check($sformatf("v%0d.strobes", i), 32'(stb), 32'(e.stb));
   endtask

   initial begin
      //   botoes  h  z  n   jogada  f tem to est stb
      add(4'b0000, 1, 1, 2,  4'b0000, 0, 0, 0, 0, 0);
      // clean press, hold 20 cycles, release
      add(4'b0100, 1, 1, 6,  4'b0000, 0, 0, 0, 1, 0);
      add(4'b0100, 1, 1, 1,  4'b0100, 1, 1, 0, 2, 1);
      add(4'b0100, 1, 1, 13, 4'b0100, 0, 1, 0, 2, 0);
      add(4'b0000, 1, 1, 2,  4'b0100, 0, 1, 0, 2, 0);
      add(4'b0000, 1, 1, 1,  4'b0100, 0, 0, 0, 3, 0);
      add(4'b0000, 1, 1, 3,  4'b0100, 0, 0, 0, 3, 0);
      add(4'b0000, 1, 1, 1,  4'b0100, 0, 0, 0, 0, 0);
      // bit 1 bouncing every 2 cycles, then held
      add(4'b0010, 1, 1, 2,  4'b0100, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 1, 2,  4'b0100, 0, 0, 0, 1, 0);
      add(4'b0010, 1, 1, 2,  4'b0100, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 1, 2,  4'b0100, 0, 0, 0, 1, 0);
      add(4'b0010, 1, 1, 2,  4'b0100, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 1, 2,  4'b0100, 0, 0, 0, 1, 0);
      add(4'b0010, 1, 1, 6,  4'b0100, 0, 0, 0, 1, 0);
      add(4'b0010, 1, 1, 1,  4'b0010, 1, 1, 0, 2, 1);
      add(4'b0000, 1, 1, 7,  4'b0010, 0, 0, 0, 0, 0);
      // two buttons at once
      add(4'b0011, 1, 1, 10, 4'b0010, 0, 0, 0, 4, 0);
      add(4'b0000, 1, 1, 3,  4'b0010, 0, 0, 0, 3, 0);
      add(4'b0000, 1, 1, 4,  4'b0010, 0, 0, 0, 0, 0);
      // press while disabled, enable while held, then a normal press
      add(4'b1000, 0, 1, 7,  4'b0010, 0, 1, 0, 2, 0);
      add(4'b1000, 1, 1, 5,  4'b0010, 0, 1, 0, 2, 0);
      add(4'b0000, 1, 1, 7,  4'b0010, 0, 0, 0, 0, 0);
      add(4'b0001, 1, 1, 7,  4'b0001, 1, 1, 0, 2, 1);
      add(4'b0000, 1, 1, 7,  4'b0001, 0, 0, 0, 0, 0);
      // watchdog: terminal count, hold, clear, reassert, disable
      add(4'b0000, 1, 1, 1,  4'b0001, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 9,  4'b0001, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 1,  4'b0001, 0, 0, 1, 0, 0);
      add(4'b0000, 1, 0, 5,  4'b0001, 0, 0, 1, 0, 0);
      add(4'b0000, 1, 1, 1,  4'b0001, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 9,  4'b0001, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 1,  4'b0001, 0, 0, 1, 0, 0);
      add(4'b0000, 0, 0, 1,  4'b0001, 0, 0, 0, 0, 0);
      // press landing exactly on the terminal count
      add(4'b0000, 1, 1, 1,  4'b0001, 0, 0, 0, 0, 0);
      add(4'b0000, 1, 0, 3,  4'b0001, 0, 0, 0, 0, 0);
      add(4'b0100, 1, 0, 6,  4'b0001, 0, 0, 0, 1, 0);
      add(4'b0100, 1, 0, 1,  4'b0100, 1, 1, 0, 2, 1);
      add(4'b0100, 1, 0, 9,  4'b0100, 0, 1, 0, 2, 0);
      add(4'b0100, 1, 0, 1,  4'b0100, 0, 1, 1, 2, 0);
      // after a mid-press reset, button still held
      add(4'b0100, 1, 1, 6,  4'b0000, 0, 0, 0, 1, 0);
      add(4'b0100, 1, 1, 1,  4'b0100, 1, 1, 0, 2, 1);
      add(4'b0000, 1, 1, 7,  4'b0100, 0, 0, 0, 0, 0);

      // reset state
      repeat (2) @(posedge clock);
      #1;
      check_zero("reset");
      reset = 1'b1;

      for (int i = 0; i < 39; i++) run_vec(i);

      // asynchronous reset while PRESSIONADO with timeout set
      #3;
      reset = 1'b0;
      #1;
      check_zero("rst_mid");
      @(posedge clock);
      #1;
      check_zero("rst_hold");
      reset = 1'b1;

      for (int i = 39; i < vecs.size(); i++) run_vec(i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/condicionador_jogada.md
# condicionador_jogada

Upstream input stage of the sequence-game circuit. Synchronizes and debounces the four raw `botoes`, rejects multi-button presses, and delivers one registered one-hot `jogada` with a single-cycle `jogada_feita` strobe per physical press. It also runs the per-move timeout watchdog, so the datapath/control unit receives clean `jogada_feita`, `tem_jogada` and `timeout` signals.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release (≥2).
- `TIMEOUT_CYCLES`, default 5000: enabled cycles without an accepted press before `timeout` asserts (≥2).
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; forces reset state immediately.
- `botoes`  in  4  raw, asynchronous push-buttons, active-high.
- `habilita`  in  1  from control unit: a press may be delivered and the watchdog runs.
- `zera_timeout`  in  1  synchronous clear of the watchdog counter and `timeout`.
- `jogada`  out  4  last accepted one-hot move, registered.
- `jogada_feita`  out  1  one-cycle strobe on acceptance.
- `tem_jogada`  out  1  high while the accepted button is held (state PRESSIONADO).
- `timeout`  out  1  sticky watchdog flag.
- `db_estado`  out  3  FSM state code for debug display.

## Operation
- Reset (`reset`=0): sync flops, debounce counter, watchdog counter cleared; state OCIOSO; `jogada`=0, `jogada_feita`=0, `tem_jogada`=0, `timeout`=0, `db_estado`=0.
- Synchronizer: two flops per bit; FSM sees `b_s` only.
- States/codes: OCIOSO=0, FILTRANDO=1, PRESSIONADO=2, SOLTANDO=3, INVALIDO=4; codes 5–7 unreachable, decode to OCIOSO.
- OCIOSO: `b_s`=0 stay. `b_s` one-hot → FILTRANDO, capture `b_s` as candidate, counter=0. `b_s` nonzero, not one-hot → INVALIDO.
- FILTRANDO: `b_s`==candidate → counter+1; when counter==DEBOUNCE_CYCLES-1 and still equal → PRESSIONADO. `b_s`=0 → OCIOSO. `b_s` different one-hot → restart with new candidate, counter=0. `b_s` not one-hot → INVALIDO.
- Entry to PRESSIONADO: if `habilita`=1 that edge, `jogada`←candidate and `jogada_feita`=1 for exactly one cycle; if `habilita`=0, no strobe and `jogada` unchanged (press is consumed, never delivered late).
- PRESSIONADO: `tem_jogada`=1; leave to SOLTANDO (counter=0) when `b_s`≠candidate (release or extra button).
- SOLTANDO: `b_s`=0 → counter+1; any nonzero `b_s` → counter=0, stay; counter==DEBOUNCE_CYCLES-1 with `b_s`=0 → OCIOSO.
- INVALIDO: no strobe; `b_s`=0 → SOLTANDO (counter=0); otherwise stay.
- Watchdog: counter cleared while `habilita`=0, on `zera_timeout`, or on a strobe edge; otherwise increments while `timeout`=0. When counter==TIMEOUT_CYCLES-1 and incrementing → `timeout`←1, held until `zera_timeout`=1 or `habilita`=0. Counter width = clog2(TIMEOUT_CYCLES); no wrap (saturates by holding once `timeout`=1).
- Simultaneous: strobe edge coinciding with terminal count → strobe wins, `timeout` stays 0. `zera_timeout` dominates increment. Reset mid-press: outputs clear; button still held after reset is treated as a fresh press (normal filtering).

## Timing
- Press latency: with `botoes` stable one-hot before edge 1, `b_s` valid after edge 2, FILTRANDO entered at edge 3, PRESSIONADO at edge 3+DEBOUNCE_CYCLES; `jogada_feita`/`jogada` visible in the cycle after that edge (DEBOUNCE_CYCLES=4 → after edge 7).
- Release-to-rearm: 2 sync + 1 + DEBOUNCE_CYCLES edges until OCIOSO.
- Timeout: with `habilita` rising before edge 1 and no press, `timeout`=1 after edge TIMEOUT_CYCLES.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Clean press `botoes`=4'b0100 for 20 cycles, `habilita`=1, DEBOUNCE=4 → one `jogada_feita` pulse after edge 7, `jogada`=4'b0100, `tem_jogada`=1 until release +3 edges.
- Bounce: toggle bit 1 every 2 cycles for 12 cycles then hold → no strobe during bounce; exactly one strobe 7 edges after final stable level.
- Two buttons 4'b0011 held 10 cycles → `db_estado`=4, no strobe, `jogada` unchanged; after release returns to 0.
- `habilita`=0 during press, raised while held → no strobe at all; next clean press delivers normally.
- TIMEOUT=10, `habilita`=1, no press → `timeout`=1 after edge 10, holds; `zera_timeout` pulse → 0 next cycle, reasserts 10 edges later; press landing exactly at terminal count → strobe, `timeout`=0.
- Assert `reset`=0 mid-PRESSIONADO → all outputs 0 immediately; release `reset` with button held → new strobe after 3+DEBOUNCE edges.
